// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 frame decoder.
//   - dht11_state_e : decoder FSM state encoding
//   - FRAME_BITS    : data bits per sensor frame
//   - BYTE_*        : byte positions inside the 40-bit frame (byte 0 arrives first)
//   - DEF_*_US      : default protocol timing values in microseconds
//   - frame_byte()  : extracts byte N from a 40-bit MSB-first frame
package dht11_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_LOW  = 3'd1,
        RESP_LOW  = 3'd2,
        RESP_HIGH = 3'd3,
        BIT_LOW   = 3'd4,
        BIT_HIGH  = 3'd5,
        DONE      = 3'd6,
        ERR       = 3'd7
    } dht11_state_e;

    localparam int FRAME_BITS     = 40;
    localparam int BYTE_HUM_INT   = 0;
    localparam int BYTE_HUM_DEC   = 1;
    localparam int BYTE_TEMP_INT  = 2;
    localparam int BYTE_TEMP_DEC  = 3;
    localparam int BYTE_CHECKSUM  = 4;

    localparam int DEF_BIT1_THRESH_US = 40;
    localparam int DEF_RESP_MIN_US    = 60;
    localparam int DEF_TIMEOUT_US     = 200;

    // Byte 0 occupies the top bits because the sensor sends MSB-first.
    function automatic logic [7:0] frame_byte(input logic [FRAME_BITS-1:0] f, input int idx);
        return f[(FRAME_BITS - 1 - 8 * idx) -: 8];
    endfunction

endpackage

// File: rtl/dht11_line_sync.sv
// Two-flop synchronizer for the asynchronous DHT11 data line plus a
// previous-level flop for edge detection.
//   clk, rst : design clock, synchronous active-high reset
//   din      : raw pin level
//   rise     : one-cycle pulse, synchronized line went 0 -> 1
//   fall     : one-cycle pulse, synchronized line went 1 -> 0
// Edge pulses lag the pin by two cycles.
module dht11_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/dht11_frame_decoder.sv
// DHT11 frame decoder: after a start edge, times the sensor response
// preamble and 40 data bits on the sampled line, then latches the four
// data bytes and the checksum result. Read-only on the line.
//   clk, rst                 : design clock (1 MHz default), sync active-high reset
//   start                    : rising edge launches a frame (ignored while busy)
//   dht_in                   : raw DHT11 line level
//   busy                     : high from launch until the done/error pulse
//   hum_int..temp_dec        : frame bytes 0..3, updated only on done
//   checksum_ok              : byte 4 == low 8 bits of byte0+byte1+byte2+byte3
//   done / error             : one-cycle completion / abort pulses
//   state_dbg                : current FSM state for observation
// Handshake: start is edge-triggered with no ready; a launch is accepted
// only when busy=0, and each accepted launch ends in exactly one done or
// one error pulse, in the same cycle that busy falls.
module dht11_frame_decoder
    import dht11_pkg::*;
#(
    parameter int CLK_PER_US     = 1,
    parameter int CNT_W          = 16,
    parameter int BIT1_THRESH_US = DEF_BIT1_THRESH_US,
    parameter int RESP_MIN_US    = DEF_RESP_MIN_US,
    parameter int TIMEOUT_US     = DEF_TIMEOUT_US
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dht_in,
    output logic       busy,
    output logic [7:0] hum_int,
    output logic [7:0] hum_dec,
    output logic [7:0] temp_int,
    output logic [7:0] temp_dec,
    output logic       checksum_ok,
    output logic       done,
    output logic       error,
    output logic [2:0] state_dbg
);

    localparam logic [CNT_W-1:0] RESP_MIN  = CNT_W'(RESP_MIN_US * CLK_PER_US);
    localparam logic [CNT_W-1:0] BIT1_TH   = CNT_W'(BIT1_THRESH_US * CLK_PER_US);
    localparam logic [CNT_W-1:0] TIMEOUT   = CNT_W'(TIMEOUT_US * CLK_PER_US);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [5:0]       LAST_BIT  = 6'(FRAME_BITS - 1);

    dht11_state_e          state, next_state;
    logic                  start_q;
    logic                  start_rise;
    logic                  line_rise, line_fall, line_edge;
    logic [CNT_W-1:0]      count;
    logic [5:0]            bit_idx;
    logic [FRAME_BITS-1:0] shift;
    logic                  timeout;
    logic                  launch, shift_en, idx_clr, idx_inc;
    logic [9:0]            sum;

    dht11_line_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (dht_in),
        .rise (line_rise),
        .fall (line_fall)
    );

    assign line_edge  = line_rise | line_fall;
    assign start_rise = start & ~start_q;
    assign timeout    = (count >= TIMEOUT);
    assign state_dbg  = state;

    assign sum = 10'(frame_byte(shift, BYTE_HUM_INT))  + 10'(frame_byte(shift, BYTE_HUM_DEC)) +
                 10'(frame_byte(shift, BYTE_TEMP_INT)) + 10'(frame_byte(shift, BYTE_TEMP_DEC));

    always_comb begin
        next_state = state;
        launch     = 1'b0;
        shift_en   = 1'b0;
        idx_clr    = 1'b0;
        idx_inc    = 1'b0;
        case (state)
            IDLE: begin
                // Line edges here (e.g. the trailing low after bit 39) are ignored.
                if (start_rise) begin
                    next_state = WAIT_LOW;
                    launch     = 1'b1;
                end
            end
            WAIT_LOW: begin
                if (timeout)        next_state = ERR;
                else if (line_fall) next_state = RESP_LOW;
            end
            RESP_LOW: begin
                if (timeout)        next_state = ERR;
                else if (line_rise) next_state = (count >= RESP_MIN) ? RESP_HIGH : ERR;
            end
            RESP_HIGH: begin
                if (timeout) next_state = ERR;
                else if (line_fall) begin
                    if (count >= RESP_MIN) begin
                        next_state = BIT_LOW;
                        idx_clr    = 1'b1;
                    end else begin
                        next_state = ERR;
                    end
                end
            end
            BIT_LOW: begin
                if (timeout)        next_state = ERR;
                else if (line_rise) next_state = BIT_HIGH;
            end
            BIT_HIGH: begin
                if (timeout) next_state = ERR;
                else if (line_fall) begin
                    shift_en = 1'b1;
                    if (bit_idx == LAST_BIT) begin
                        next_state = DONE;
                    end else begin
                        next_state = BIT_LOW;
                        idx_inc    = 1'b1;
                    end
                end
            end
            DONE:    next_state = IDLE;
            ERR:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            start_q     <= 1'b0;
            count       <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            hum_int     <= '0;
            hum_dec     <= '0;
            temp_int    <= '0;
            temp_dec    <= '0;
            checksum_ok <= 1'b0;
        end else begin
            state   <= next_state;
            start_q <= start;

            // Launch also clears the counter so WAIT_LOW times from entry,
            // not from whenever the idle line last moved.
            if (launch || line_edge)   count <= '0;
            else if (count != CNT_MAX) count <= count + CNT_W'(1);

            if (launch)        shift <= '0;
            else if (shift_en) shift <= {shift[FRAME_BITS-2:0], (count > BIT1_TH)};

            if (idx_clr)      bit_idx <= '0;
            else if (idx_inc) bit_idx <= bit_idx + 6'd1;

            // Registered so busy falls in the same cycle done/error rises.
            busy  <= (next_state != IDLE);
            done  <= (state == DONE);
            error <= (state == ERR);

            if (state == DONE) begin
                hum_int     <= frame_byte(shift, BYTE_HUM_INT);
                hum_dec     <= frame_byte(shift, BYTE_HUM_DEC);
                temp_int    <= frame_byte(shift, BYTE_TEMP_INT);
                temp_dec    <= frame_byte(shift, BYTE_TEMP_DEC);
                checksum_ok <= (sum[7:0] == frame_byte(shift, BYTE_CHECKSUM));
            end
        end
    end

endmodule

// File: tb/tb_dht11_frame_decoder.sv
module tb_dht11_frame_decoder;

    localparam int CLK_PER_US = 1;
    localparam int TIMEOUT_US = 200;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       dht_in;
    logic       busy;
    logic [7:0] hum_int, hum_dec, temp_int, temp_dec;
    logic       checksum_ok, done, error;
    logic [2:0] state_dbg;

    always #5 clk = ~clk;

    dht11_frame_decoder #(.CLK_PER_US(CLK_PER_US), .TIMEOUT_US(TIMEOUT_US)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dht_in      (dht_in),
        .busy        (busy),
        .hum_int     (hum_int),
        .hum_dec     (hum_dec),
        .temp_int    (temp_int),
        .temp_dec    (temp_dec),
        .checksum_ok (checksum_ok),
        .done        (done),
        .error       (error),
        .state_dbg   (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_done = 0;
    int n_err = 0;
    int busy_rise_cyc = 0;
    int err_cyc = 0;
    logic busy_prev = 1'b0;
    logic [39:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        cyc++;
        if (busy && !busy_prev) busy_rise_cyc = cyc;
        busy_prev = busy;
        if (done) begin
            n_done++;
            check("busy_low_at_done", busy, 0);
        end
        if (error) begin
            n_err++;
            err_cyc = cyc;
            check("busy_low_at_error", busy, 0);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic line(input logic lvl, input int us);
        dht_in = lvl;
        repeat (us * CLK_PER_US) @(posedge clk);
        #1;
    endtask

    task automatic launch();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_head(input bit rnd);
        launch();
        line(1'b1, rnd ? $urandom_range(20, 40) : 30);
        line(1'b0, rnd ? $urandom_range(75, 85) : 80);
        line(1'b1, rnd ? $urandom_range(75, 85) : 80);
    endtask

    task automatic send_bits(input logic [39:0] bits, input int n, input bit rnd, input int glitch_bit);
        for (int i = 0; i < n; i++) begin
            int lo, hi;
            lo = rnd ? $urandom_range(45, 55) : 50;
            if (bits[39 - i]) hi = rnd ? $urandom_range(65, 75) : 70;
            else              hi = rnd ? $urandom_range(22, 30) : 27;
            if (i == glitch_bit) begin
                // Second start edge while the frame is in progress.
                dht_in = 1'b0;
                start  = 1'b1;
                repeat (2) @(posedge clk); #1;
                start  = 1'b0;
                line(1'b0, lo - 2);
            end else begin
                line(1'b0, lo);
            end
            line(1'b1, hi);
        end
    endtask

    task automatic wait_event(input int d0, input int e0, input int budget);
        int k = 0;
        while (n_done == d0 && n_err == e0 && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        check("event_within_budget", (n_done != d0 || n_err != e0), 1);
    endtask

    // Full frame with reference-model checking of the latched result.
    task automatic run_frame(input logic [39:0] bits, input bit rnd, input int glitch_bit, input string tag);
        int d0, e0, s;
        logic [39:0] f;
        logic [7:0] b [5];
        d0 = n_done;
        e0 = n_err;
        exp_q.push_back(bits);
        send_head(rnd);
        send_bits(bits, 40, rnd, glitch_bit);
        dht_in = 1'b0;
        wait_event(d0, e0, 100);
        line(1'b0, 50);
        line(1'b1, 20);
        check({tag, "_done_count"}, n_done - d0, 1);
        check({tag, "_err_count"}, n_err - e0, 0);
        f = exp_q.pop_front();
        for (int k = 0; k < 5; k++) b[k] = f[39 - 8 * k -: 8];
        s = int'(b[0]) + int'(b[1]) + int'(b[2]) + int'(b[3]);
        check({tag, "_hum_int"},  hum_int,  b[0]);
        check({tag, "_hum_dec"},  hum_dec,  b[1]);
        check({tag, "_temp_int"}, temp_int, b[2]);
        check({tag, "_temp_dec"}, temp_dec, b[3]);
        check({tag, "_checksum_ok"}, checksum_ok, ((s % 256) == int'(b[4])) ? 1 : 0);
        check({tag, "_busy_after"}, busy, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int d0, e0;
        logic [39:0] rf;
        logic [7:0] rb [4];
        int rs;

        rst    = 1'b1;
        start  = 1'b0;
        dht_in = 1'b1;
        repeat (3) @(posedge clk); #1;
        rst = 1'b0;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_error", error, 0);
        check("reset_hum_int", hum_int, 0);
        check("reset_temp_int", temp_int, 0);
        check("reset_checksum_ok", checksum_ok, 0);
        line(1'b1, 10);

        run_frame({8'h37, 8'h00, 8'h19, 8'h00, 8'h50}, 1'b0, -1, "nominal");
        run_frame({8'h37, 8'h00, 8'h19, 8'h00, 8'h51}, 1'b0, -1, "bad_sum");

        // Line held high after launch: timeout in WAIT_LOW.
        d0 = n_done; e0 = n_err;
        launch();
        wait_event(d0, e0, 400);
        check("stuck_high_err", n_err - e0, 1);
        check("stuck_high_done", n_done - d0, 0);
        check("stuck_high_latency", err_cyc - busy_rise_cyc, TIMEOUT_US * CLK_PER_US + 2);
        check("stuck_high_hum_held", hum_int, 8'h37);
        check("stuck_high_csum_held", checksum_ok, 0);
        line(1'b1, 10);

        // Response low too short.
        d0 = n_done; e0 = n_err;
        launch();
        line(1'b1, 30);
        line(1'b0, 30);
        line(1'b1, 20);
        wait_event(d0, e0, 100);
        check("short_resp_err", n_err - e0, 1);
        check("short_resp_done", n_done - d0, 0);
        line(1'b1, 100);

        // Line stuck high for 250 us during bit 12.
        d0 = n_done; e0 = n_err;
        send_head(1'b0);
        send_bits({8'h28, 8'h05, 8'h1A, 8'h03, 8'h4A}, 12, 1'b0, -1);
        line(1'b0, 50);
        line(1'b1, 250);
        check("bit12_stuck_err", n_err - e0, 1);
        check("bit12_stuck_done", n_done - d0, 0);
        check("bit12_stuck_temp_held", temp_int, 8'h19);
        run_frame({8'h28, 8'h05, 8'h1A, 8'h03, 8'h4A}, 1'b0, -1, "after_stuck");

        // Reset during bit 20.
        d0 = n_done; e0 = n_err;
        send_head(1'b1);
        send_bits({8'h11, 8'h22, 8'h33, 8'h44, 8'hAA}, 20, 1'b1, -1);
        line(1'b0, 10);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midreset_busy", busy, 0);
        check("midreset_hum_int", hum_int, 0);
        check("midreset_hum_dec", hum_dec, 0);
        check("midreset_temp_int", temp_int, 0);
        check("midreset_temp_dec", temp_dec, 0);
        check("midreset_checksum_ok", checksum_ok, 0);
        rst = 1'b0;
        line(1'b0, 40);
        line(1'b1, 300);
        check("midreset_no_done", n_done - d0, 0);
        check("midreset_no_err", n_err - e0, 0);

        // Extra start edge mid-frame must be ignored.
        run_frame({8'h40, 8'h01, 8'h17, 8'h09, 8'h61}, 1'b0, 5, "restart_ignored");

        // Randomized frames, roughly half with a corrupted checksum.
        for (int n = 0; n < 5; n++) begin
            for (int k = 0; k < 4; k++) rb[k] = 8'($urandom_range(0, 255));
            rs = int'(rb[0]) + int'(rb[1]) + int'(rb[2]) + int'(rb[3]);
            if ($urandom_range(0, 1) == 1) rs = rs + $urandom_range(1, 255);
            rf = {rb[0], rb[1], rb[2], rb[3], 8'(rs % 256)};
            run_frame(rf, 1'b1, -1, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dht11_frame_decoder.md
Name: dht11_frame_decoder

Overview:
Downstream stage of the DHT11 start-pulse generator. Triggered by the generator's confirm strobe, it times the sensor's response preamble and 40 data bits on the sampled single-wire line, then assembles and checksums the frame. It runs on the divided 1 MHz design clock (1 tick = 1 us at default) and only reads the line; it never drives it.

Parameters:
CLK_PER_US, 1, clock cycles per microsecond; all timing constants are scaled by this value.
CNT_W, 16, width of the pulse-duration counter; the counter saturates at all-ones.
BIT1_THRESH_US, 40, a data high phase longer than this is a '1', otherwise a '0'.
RESP_MIN_US, 60, minimum accepted length of the sensor's 80 us response low and response high phases.
TIMEOUT_US, 200, maximum time in any single line level before the frame aborts.

Ports:
clk  input  1  design clock, 1 MHz divided clock.
rst  input  1  synchronous, active-high reset.
start  input  1  confirm from the start-pulse stage; a rising edge launches a frame.
dht_in  input  1  raw sampled level of the DHT11 data line (asynchronous).
busy  output  1  high from frame launch until done or error.
hum_int  output  8  humidity integer byte (frame byte 0).
hum_dec  output  8  humidity decimal byte (byte 1).
temp_int  output  8  temperature integer byte (byte 2).
temp_dec  output  8  temperature decimal byte (byte 3).
checksum_ok  output  1  byte 4 equals (byte0+byte1+byte2+byte3) mod 256.
done  output  1  one-cycle pulse when a full 40-bit frame has been captured.
error  output  1  one-cycle pulse on timeout or response-length violation.

Behaviour:
- Reset: every output is 0, the FSM is in IDLE, counters and the 40-bit shift register are cleared. Reset applied mid-frame aborts the frame with no done or error pulse.
- dht_in passes through a 2-flop synchronizer, followed by a registered previous-level flop for edge detection. Every edge decision therefore lags the pin by 2 cycles.
- start uses internal rising-edge detection. A start edge while busy=1 is ignored.
- The duration counter resets to 0 on every synchronized edge of dht_in, increments each cycle, and saturates at all-ones.
- FSM states:
  - IDLE: on a start edge, go to WAIT_LOW and set busy=1.
  - WAIT_LOW: waits for the sensor to pull the line low (host release plus 20-40 us).
  - RESP_LOW: on a rising edge, require count >= RESP_MIN_US*CLK_PER_US, else go to ERR.
  - RESP_HIGH: on a falling edge, apply the same minimum check; then clear the bit index and go to BIT_LOW.
  - BIT_LOW: the 50 us low phase; on a rising edge go to BIT_HIGH.
  - BIT_HIGH: on a falling edge, shift in bit = (count > BIT1_THRESH_US*CLK_PER_US), MSB-first into shift[39:0]. If the index is 39, go to DONE; otherwise increment the index and go to BIT_LOW.
  - DONE: latch the bytes and checksum_ok, pulse done for 1 cycle, clear busy, go to IDLE.
  - ERR: pulse error for 1 cycle, clear busy, go to IDLE. Data outputs keep their previous values.
- Timeout: in every state except IDLE, DONE and ERR, count >= TIMEOUT_US*CLK_PER_US forces ERR.
- The trailing 50 us sensor low after bit 39 is not timed. Its rising edge arrives in IDLE and is ignored.
- The checksum sum is 10 bits wide and compared on its low 8 bits. done is asserted even when checksum_ok=0.
- Data outputs change only in DONE and are held until the next DONE or rst.
- The start edge and a line edge arriving in the same cycle in IDLE: the start is taken and the line edge is ignored.

Decomposition:
- Shared package dht11_pkg holds:
  - FSM state encoding (IDLE, WAIT_LOW, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, DONE, ERR).
  - Protocol constants: FRAME_BITS=40, the byte index positions, and default timing values in us.
- One sub-module, dht11_line_sync: the 2-flop synchronizer plus rise/fall pulse outputs, with clk/rst.

Test Plan:
- Frame bytes 0x37,0x00,0x19,0x00,0x50 at nominal timing (80/80 us preamble; 50 us low, 27 us high = 0, 70 us high = 1) -> done pulses once; hum_int=0x37, temp_int=0x19, checksum_ok=1, busy falls the same cycle.
- Same frame with byte 4 = 0x51 -> done=1, checksum_ok=0, bytes still latched as sent.
- Start edge with the line held high -> error pulses exactly TIMEOUT_US cycles (+2 sync) after entry to WAIT_LOW, busy=0, outputs unchanged.
- Response low of only 30 us -> error on its rising edge; no done.
- Line stuck high at 250 us during bit 12 -> error at the 200 us mark. A following good frame 0x28,0x05,0x1A,0x03,0x4A decodes correctly.
- rst asserted during bit 20 -> all outputs 0 next cycle. A second start edge pulsed while busy -> ignored; exactly one done per frame.
